// File: rtl/result_serial_fifo_pkg.sv
// Shared constants and helpers for the result serialising FIFO.
// Word order is least-significant word first; word_lsb() is the single place that encodes it.
package result_serial_fifo_pkg;

    localparam int DEF_RESULT_W = 3072;
    localparam int DEF_WORD_W   = 32;
    localparam int DEF_SLOTS    = 4;

    localparam bit LSB_WORD_FIRST = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Index widths must stay at least one bit so degenerate configurations still elaborate.
    function automatic int width_of(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    localparam int WORDS = DEF_RESULT_W / DEF_WORD_W;
    localparam int PTR_W = clog2(DEF_SLOTS);
    localparam int IDX_W = clog2(WORDS);

    function automatic int word_lsb(input int k, input int word_w, input int words);
        return LSB_WORD_FIRST ? (k * word_w) : ((words - 1 - k) * word_w);
    endfunction

endpackage

// File: rtl/result_serial_fifo_ram.sv
// Slot storage: full-width write of one result, combinational single-word read.
module result_slot_ram
    import result_serial_fifo_pkg::*;
#(
    parameter int RESULT_W = DEF_RESULT_W,
    parameter int WORD_W   = DEF_WORD_W,
    parameter int SLOTS    = DEF_SLOTS,
    parameter int PTR_W_P  = width_of(DEF_SLOTS),
    parameter int IDX_W_P  = width_of(DEF_RESULT_W / DEF_WORD_W)
) (
    input  logic                clk_in,
    input  logic                wr_en,
    input  logic [PTR_W_P-1:0]  wr_slot,
    input  logic [RESULT_W-1:0] wr_data,
    input  logic [PTR_W_P-1:0]  rd_slot,
    input  logic [IDX_W_P-1:0]  rd_word,
    output logic [WORD_W-1:0]   rd_data
);

    localparam int WORD_CNT = RESULT_W / WORD_W;

    logic [RESULT_W-1:0] mem [SLOTS];
    int                  word_off;

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_slot] <= wr_data;
        end
    end

    always_comb begin
        word_off = word_lsb(int'(rd_word), WORD_W, WORD_CNT);
        rd_data  = mem[rd_slot][word_off +: WORD_W];
    end

endmodule

// File: rtl/result_serial_fifo.sv
// Buffers SLOTS wide results and returns them as a word stream with last-word marking,
// flagging overflow and underflow as registered one-cycle pulses.
module result_serial_fifo
    import result_serial_fifo_pkg::*;
#(
    parameter int RESULT_W = DEF_RESULT_W,
    parameter int WORD_W   = DEF_WORD_W,
    parameter int SLOTS    = DEF_SLOTS
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          write_en,
    input  logic [RESULT_W-1:0]           final_result,
    input  logic                          rd_en,
    output logic [WORD_W-1:0]             read_data,
    output logic                          read_valid,
    output logic                          read_last,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [clog2(SLOTS+1)-1:0]     slot_count,
    output logic                          write_overflow,
    output logic                          read_underflow
);

    localparam int WORD_CNT   = RESULT_W / WORD_W;
    localparam int SLOT_PTR_W = width_of(SLOTS);
    localparam int WORD_IDX_W = width_of(WORD_CNT);
    localparam int CNT_W      = clog2(SLOTS + 1);

    generate
        if ((RESULT_W % WORD_W) != 0) begin : g_bad_width
            $error("RESULT_W must be a multiple of WORD_W");
        end
        if ((SLOTS < 2) || ((SLOTS & (SLOTS - 1)) != 0)) begin : g_bad_slots
            $error("SLOTS must be a power of two and at least 2");
        end
    endgenerate

    logic [SLOT_PTR_W-1:0] wr_ptr;
    logic [SLOT_PTR_W-1:0] rd_ptr;
    logic [WORD_IDX_W-1:0] word_idx;
    logic [CNT_W-1:0]      count;
    logic [WORD_W-1:0]     ram_word;

    logic wr_acc;
    logic rd_acc;
    logic last_word;
    logic slot_done;

    assign fifo_full  = (count == CNT_W'(SLOTS));
    assign fifo_empty = (count == '0);
    assign slot_count = count;

    // Accept decisions use only registered state, so a same-edge read never rescues a full write.
    assign wr_acc    = write_en && !fifo_full;
    assign rd_acc    = rd_en && !fifo_empty;
    assign last_word = (word_idx == WORD_IDX_W'(WORD_CNT - 1));
    assign slot_done = rd_acc && last_word;

    result_slot_ram #(
        .RESULT_W (RESULT_W),
        .WORD_W   (WORD_W),
        .SLOTS    (SLOTS),
        .PTR_W_P  (SLOT_PTR_W),
        .IDX_W_P  (WORD_IDX_W)
    ) u_slot_ram (
        .clk_in  (clk_in),
        .wr_en   (wr_acc),
        .wr_slot (wr_ptr),
        .wr_data (final_result),
        .rd_slot (rd_ptr),
        .rd_word (word_idx),
        .rd_data (ram_word)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            word_idx       <= '0;
            count          <= '0;
            read_data      <= '0;
            read_valid     <= 1'b0;
            read_last      <= 1'b0;
            write_overflow <= 1'b0;
            read_underflow <= 1'b0;
        end else begin
            write_overflow <= write_en && fifo_full;
            read_underflow <= rd_en && fifo_empty;
            read_valid     <= rd_acc;
            read_last      <= slot_done;

            if (wr_acc) begin
                wr_ptr <= wr_ptr + SLOT_PTR_W'(1);
            end

            if (rd_acc) begin
                read_data <= ram_word;
                if (last_word) begin
                    word_idx <= '0;
                    rd_ptr   <= rd_ptr + SLOT_PTR_W'(1);
                end else begin
                    word_idx <= word_idx + WORD_IDX_W'(1);
                end
            end

            unique case ({wr_acc, slot_done})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_result_serial_fifo.sv
// Directed bench: a 128-bit/4-word instance for ordering and flag corner cases,
// and a default 3072-bit instance for mid-result reset.
module tb_result_serial_fifo;

    localparam int SW = 128;
    localparam int LW = 3072;

    logic          clk_in = 1'b0;
    logic          rst;

    logic          s_wen, s_ren;
    logic [SW-1:0] s_res;
    logic [31:0]   s_data;
    logic          s_valid, s_last, s_full, s_empty, s_ovf, s_und;
    logic [2:0]    s_cnt;

    logic          l_wen, l_ren;
    logic [LW-1:0] l_res;
    logic [31:0]   l_data;
    logic          l_valid, l_last, l_full, l_empty, l_ovf, l_und;
    logic [2:0]    l_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    result_serial_fifo #(.RESULT_W(SW), .WORD_W(32), .SLOTS(4)) dut_s (
        .clk_in(clk_in), .rst(rst), .write_en(s_wen), .final_result(s_res), .rd_en(s_ren),
        .read_data(s_data), .read_valid(s_valid), .read_last(s_last), .fifo_full(s_full),
        .fifo_empty(s_empty), .slot_count(s_cnt), .write_overflow(s_ovf), .read_underflow(s_und)
    );

    result_serial_fifo dut_l (
        .clk_in(clk_in), .rst(rst), .write_en(l_wen), .final_result(l_res), .rd_en(l_ren),
        .read_data(l_data), .read_valid(l_valid), .read_last(l_last), .fifo_full(l_full),
        .fifo_empty(l_empty), .slot_count(l_cnt), .write_overflow(l_ovf), .read_underflow(l_und)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    function automatic logic [31:0] mk_word(input int i, input int k);
        return 32'hC0DE_0000 | (32'(i) << 4) | 32'(k);
    endfunction

    function automatic logic [SW-1:0] mk_res(input int i);
        logic [SW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = mk_word(i, k);
        return r;
    endfunction

    task automatic check_small_reset(input string tag);
        check({tag, "_data"},  s_data, 0);
        check({tag, "_valid"}, s_valid, 0);
        check({tag, "_last"},  s_last, 0);
        check({tag, "_full"},  s_full, 0);
        check({tag, "_empty"}, s_empty, 1);
        check({tag, "_cnt"},   s_cnt, 0);
        check({tag, "_ovf"},   s_ovf, 0);
        check({tag, "_und"},   s_und, 0);
    endtask

    initial begin
        logic [SW-1:0] r1;
        rst = 1'b1;
        s_wen = 0; s_ren = 0; s_res = '0;
        l_wen = 0; l_ren = 0; l_res = '0;
        @(negedge clk_in);
        tick();
        tick();
        check_small_reset("rst_s");
        rst = 1'b0;

        // Basic 4-word drain, LSB word first.
        r1 = 128'h44444444_33333333_22222222_11111111;
        s_res = r1; s_wen = 1;
        tick();
        s_wen = 0;
        check("wr1_empty", s_empty, 0);
        check("wr1_cnt", s_cnt, 1);
        s_ren = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rd1_data%0d", k), s_data, 32'h11111111 * (k + 1));
            check($sformatf("rd1_valid%0d", k), s_valid, 1);
            check($sformatf("rd1_last%0d", k), s_last, (k == 3));
        end
        s_ren = 0;
        check("rd1_empty", s_empty, 1);
        tick();
        check("idle_valid", s_valid, 0);
        check("idle_hold", s_data, 32'h44444444);

        // Fill to full, then overflow.
        for (int i = 0; i < 4; i++) begin
            s_res = mk_res(i); s_wen = 1;
            tick();
        end
        check("fill_full", s_full, 1);
        check("fill_cnt", s_cnt, 4);
        s_res = mk_res(9);
        tick();
        s_wen = 0;
        check("ovf_pulse", s_ovf, 1);
        check("ovf_cnt", s_cnt, 4);
        tick();
        check("ovf_clear", s_ovf, 0);

        // Read three words of slot 0, then write on the same edge as its last word.
        s_ren = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("s0_data%0d", k), s_data, mk_word(0, k));
        end
        s_wen = 1; s_res = mk_res(8);
        tick();
        check("race_ovf", s_ovf, 1);
        check("race_last", s_last, 1);
        check("race_data", s_data, mk_word(0, 3));
        check("race_cnt", s_cnt, 3);
        check("race_full", s_full, 0);
        s_ren = 0; s_res = mk_res(4);
        tick();
        s_wen = 0;
        check("retry_cnt", s_cnt, 4);
        check("retry_full", s_full, 1);
        check("retry_ovf", s_ovf, 0);

        // Continuous drain across four results: no bubble at slot boundaries.
        s_ren = 1;
        for (int n = 0; n < 16; n++) begin
            tick();
            check($sformatf("drain_data%0d", n), s_data, mk_word(n / 4 + 1, n % 4));
            check($sformatf("drain_valid%0d", n), s_valid, 1);
            check($sformatf("drain_last%0d", n), s_last, (n % 4) == 3);
        end
        check("drain_empty", s_empty, 1);
        check("drain_cnt", s_cnt, 0);

        // Underflow with a concurrent write.
        s_wen = 1; s_res = mk_res(5);
        tick();
        s_wen = 0;
        check("und_pulse", s_und, 1);
        check("und_valid", s_valid, 0);
        check("und_hold", s_data, mk_word(4, 3));
        check("und_cnt", s_cnt, 1);
        tick();
        s_ren = 0;
        check("und_next_data", s_data, mk_word(5, 0));
        check("und_next_valid", s_valid, 1);
        check("und_clear", s_und, 0);

        // Default-width instance: partial read, then reset mid-result.
        for (int k = 0; k < 96; k++) l_res[k*32 +: 32] = 32'hAAAA_0000 | 32'(k);
        l_wen = 1;
        tick();
        l_wen = 0;
        l_ren = 1;
        for (int k = 0; k < 50; k++) begin
            tick();
            check($sformatf("big_data%0d", k), l_data, 32'hAAAA_0000 | 32'(k));
            check($sformatf("big_last%0d", k), l_last, 0);
        end
        l_ren = 0; rst = 1;
        tick();
        rst = 0;
        check("big_rst_data", l_data, 0);
        check("big_rst_valid", l_valid, 0);
        check("big_rst_last", l_last, 0);
        check("big_rst_full", l_full, 0);
        check("big_rst_empty", l_empty, 1);
        check("big_rst_cnt", l_cnt, 0);
        check("big_rst_ovf", l_ovf, 0);
        check("big_rst_und", l_und, 0);
        check_small_reset("rst_s2");

        for (int k = 0; k < 96; k++) l_res[k*32 +: 32] = 32'h5555_0000 | 32'(k);
        l_wen = 1;
        tick();
        l_wen = 0; l_ren = 1;
        tick();
        check("big_new_w0", l_data, 32'h5555_0000);
        tick();
        l_ren = 0;
        check("big_new_w1", l_data, 32'h5555_0001);
        check("big_new_cnt", l_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_serial_fifo.md
# result_serial_fifo

Parametrised successor to the existing single-result write FIFO. It buffers up to SLOTS complete wide results, each RESULT_W bits and typically a full Toeplitz hash output. It returns them as a stream of WORD_W-bit words, least-significant word first, with per-word valid and last-word marking. It sits between the Toeplitz result register and the narrow readout path (host/DMA side), and it reports overflow and underflow instead of silently dropping.

## Interface
- RESULT_W, 3072, width of one result; must be a multiple of WORD_W (elaboration error otherwise)
- WORD_W, 32, readout word width
- SLOTS, 4, results buffered; power of two, >= 2
- clk_in  in  1  single clock; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- write_en  in  1  push final_result as one slot this cycle
- final_result  in  RESULT_W  result to store
- rd_en  in  1  pop one word
- read_data  out  WORD_W  registered output word
- read_valid  out  1  read_data was updated by an accepted read last edge
- read_last  out  1  qualifies read_valid: word was the final word of its result
- fifo_full  out  1  all SLOTS occupied
- fifo_empty  out  1  no unread words
- slot_count  out  clog2(SLOTS+1)  occupied slots, including a partially read slot
- write_overflow  out  1  one-cycle pulse: write_en while fifo_full
- read_underflow  out  1  one-cycle pulse: rd_en while fifo_empty

## Operation
- WORDS = RESULT_W/WORD_W.
- Word k of a result is final_result[k*WORD_W +: WORD_W], for k = 0..WORDS-1.
- State: wr_ptr and rd_ptr (slot indices, wrap modulo SLOTS), word_idx (0..WORDS-1), count.
- Write is accepted when write_en && !fifo_full:
  - slot[wr_ptr] <= final_result; wr_ptr++; count++.
- Read is accepted when rd_en && !fifo_empty:
  - read_data <= word word_idx of slot[rd_ptr]; read_valid <= 1; read_last <= (word_idx == WORDS-1).
  - If the word is the last one: word_idx <= 0, rd_ptr++, count--. Otherwise word_idx++.
- fifo_full = (count == SLOTS). fifo_empty = (count == 0). Both are decoded from registered count.
- A write while full is rejected even if a last-word read frees a slot on the same edge. write_overflow pulses and storage is unchanged.
- A read while empty is rejected even if a write lands on the same edge. read_underflow pulses and read_data holds its value.
- Simultaneous accepted write and last-word read: count is unchanged and both pointers advance.
- When no read is accepted: read_valid = 0, read_last = 0, read_data holds its value.
- Reset mid-operation discards all buffered data, including a partially read slot. Slot storage is not reset.
- Reset values:
  - read_data = 0, read_valid = 0, read_last = 0
  - fifo_full = 0, fifo_empty = 1, slot_count = 0
  - write_overflow = 0, read_underflow = 0
  - pointers, word_idx and count = 0

## Timing
- Write at edge t: fifo_empty deasserts and slot_count increments after edge t, so the result is readable from cycle t+1.
- Read latency is 1: rd_en sampled at edge t puts the word on read_data with read_valid high in the cycle after t.
- Sustained throughput is one word per clock, including across slot boundaries (no bubble after read_last).
- One full result drains in exactly WORDS accepted reads.
- fifo_full deasserts the cycle after the edge on which the last word of the oldest slot is read.
- The overflow and underflow pulses are registered: high for exactly the one cycle after the offending edge.

## Structure
- Shared package/header holds:
  - a clog2 function
  - the derived constants WORDS, PTR_W = clog2(SLOTS) and IDX_W = clog2(WORDS)
  - the word-order convention (LSB first)
- One sub-module, result_slot_ram:
  - SLOTS x RESULT_W storage, with one full-width write port (slot address)
  - one word read port (slot address, word index) selecting WORD_W bits through a mux
  - combinational read; the read_data register lives in the top.
- Top holds pointers, word_idx, count, flag/pulse registers and accept logic.

## Test plan
- RESULT_W=128, WORD_W=32: reset, write 0x44444444_33333333_22222222_11111111, then rd_en for 4 cycles.
  - read_data = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, with read_last only on the 4th.
  - fifo_empty = 1 afterwards.
- Write SLOTS=4 results back-to-back -> fifo_full = 1 and slot_count = 4. A fifth write_en -> write_overflow pulses once, and the later readout shows only the first 4 results in order.
- rd_en held continuously across two results -> 8 consecutive read_valid cycles with no gap; read_last on words 4 and 8.
- While full, a write on the same edge as the last-word read -> write rejected (overflow pulse) and slot_count drops to 3. Write next cycle -> accepted.
- rd_en when empty, with write_en on the same edge -> read_underflow pulses, read_valid = 0, write accepted, and rd_en next cycle returns word 0.
- Default RESULT_W=3072: write pattern 0x...AAAAAAAA, read 50 words, assert rst -> all outputs at reset values next cycle, fifo_empty = 1. A new write then reads from word 0.
